// File: rtl/stream_mux_rr_if.sv
// Stream bundle between N producer channels, the mux and one consumer.
// Carries per-channel valid/last/data/ready plus the registered output beat.
// Modports: slave = mux side, master = producers/consumer side.
interface stream_mux_rr_if #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 8
);
   localparam int SEL_W = $clog2(N_CH);

   logic [N_CH-1:0]       in_valid_i;
   logic [N_CH-1:0]       in_last_i;
   logic [N_CH*WIDTH-1:0] in_data_i;
   logic [N_CH-1:0]       in_ready_o;
   logic                  out_valid_o;
   logic [WIDTH-1:0]      out_data_o;
   logic                  out_last_o;
   logic [SEL_W-1:0]      out_ch_o;
   logic                  out_ready_i;

   modport slave (
      input  in_valid_i, in_last_i, in_data_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o, out_last_o, out_ch_o
   );

   modport master (
      output in_valid_i, in_last_i, in_data_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o, out_last_o, out_ch_o
   );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel packet mux, fixed-select or round-robin, grant held until in_last.
// Latency: 1 cycle from accepted input beat to out_valid_o (single output register).
// Backpressure: out_ready_i low with a held beat freezes the output and drops all in_ready.
// Ports: clk_i/rst_i (async active-high), mode_i (0 fixed, 1 round-robin), sel_i,
//        bus (stream_mux_rr_if.slave: inputs, readies, registered output beat), locked_o.
// Optional: define STREAM_MUX_PKT_CNT_EN to add pkt_cnt_o, a saturating count of
//           packets completed at the output.
module stream_mux_rr #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 8,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             mode_i,
   input  logic [SEL_W-1:0] sel_i,
   stream_mux_rr_if.slave   bus,
   output logic             locked_o
`ifdef STREAM_MUX_PKT_CNT_EN
   ,
   output logic [15:0]      pkt_cnt_o
`endif
);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_last_q, out_last_d;
   logic [SEL_W-1:0] out_ch_q, out_ch_d;

   logic             load_en;
   logic             req;
   logic [SEL_W-1:0] g;
   logic             xfer;

   assign load_en = !out_valid_q || bus.out_ready_i;

   // Candidate channel selection
   always_comb begin
      int               j;
      logic [SEL_W-1:0] idx;
      g   = '0;
      req = 1'b0;
      j   = 0;
      idx = '0;
      if (state_q == LOCK) begin
         // Mid-packet: grant stays on the locked channel even if it goes idle.
         g   = lock_ch_q;
         req = 1'b1;
      end else if (!mode_i) begin
         // Out-of-range select (non-power-of-2 N_CH) is simply no request.
         if (int'(sel_i) < N_CH) begin
            g   = sel_i;
            req = bus.in_valid_i[sel_i];
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N_CH) j = j - N_CH;
            idx = SEL_W'(j);
            if (!req && bus.in_valid_i[idx]) begin
               req = 1'b1;
               g   = idx;
            end
         end
      end
   end

   // Ready is gated by reset so nothing is handed over while the block is held.
   always_comb begin
      bus.in_ready_o = '0;
      if (load_en && req && !rst_i) bus.in_ready_o[g] = 1'b1;
   end

   assign xfer = load_en && req && !rst_i && bus.in_valid_i[g];

   always_comb begin
      state_d     = state_q;
      lock_ch_d   = lock_ch_q;
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_ch_d    = out_ch_q;
      if (load_en) begin
         out_valid_d = xfer;
         if (xfer) begin
            out_data_d = bus.in_data_i[int'(g)*WIDTH +: WIDTH];
            out_last_d = bus.in_last_i[g];
            out_ch_d   = g;
         end
      end
      if (xfer) begin
         if (bus.in_last_i[g]) begin
            state_d = IDLE;
            // Pointer moves in both modes so round-robin resumes after the last server.
            ptr_d   = (int'(g) == N_CH - 1) ? '0 : g + SEL_W'(1);
         end else begin
            state_d   = LOCK;
            lock_ch_d = g;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         lock_ch_q   <= '0;
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_ch_q    <= '0;
      end else begin
         state_q     <= state_d;
         lock_ch_q   <= lock_ch_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_ch_q    <= out_ch_d;
      end
   end

   assign bus.out_valid_o = out_valid_q;
   assign bus.out_data_o  = out_data_q;
   assign bus.out_last_o  = out_last_q;
   assign bus.out_ch_o    = out_ch_q;
   assign locked_o        = (state_q == LOCK);

`ifdef STREAM_MUX_PKT_CNT_EN
   logic [15:0] pkt_cnt_q, pkt_cnt_d;

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (out_valid_q && bus.out_ready_i && out_last_q && (pkt_cnt_q != 16'hFFFF))
         pkt_cnt_d = pkt_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) pkt_cnt_q <= '0;
      else       pkt_cnt_q <= pkt_cnt_d;
   end

   assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (N_CH=4, WIDTH=8).
// Drives inputs 1 time unit after the rising edge and samples outputs there too.
// Packet-counter scenario runs only when STREAM_MUX_PKT_CNT_EN is defined.
module tb_stream_mux_rr;

   logic       clk;
   logic       rst;
   logic       mode;
   logic [1:0] sel;
   logic       locked;
`ifdef STREAM_MUX_PKT_CNT_EN
   logic [15:0] pkt_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   stream_mux_rr_if #(.N_CH(4), .WIDTH(8)) bus ();

   stream_mux_rr #(.N_CH(4), .WIDTH(8)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .mode_i   (mode),
      .sel_i    (sel),
      .bus      (bus),
      .locked_o (locked)
`ifdef STREAM_MUX_PKT_CNT_EN
      ,
      .pkt_cnt_o(pkt_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int ch, input logic [7:0] v);
      bus.in_data_i[ch*8 +: 8] = v;
   endtask

   task automatic test_reset();
      rst = 1'b1; mode = 1'b1;
      bus.in_valid_i = 4'b1111; bus.in_last_i = 4'b1111;
      bus.in_data_i = 32'h13121110;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%0h exp=0", bus.out_valid_o); end
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked got=%0h exp=0", locked); end
      n_checks++; if (bus.out_ch_o !== 2'd0) begin n_fail++; $display("FAIL rst_out_ch got=%0h exp=0", bus.out_ch_o); end
      n_checks++; if (bus.out_data_o !== 8'h00) begin n_fail++; $display("FAIL rst_out_data got=%0h exp=0", bus.out_data_o); end
      n_checks++; if (bus.out_last_o !== 1'b0) begin n_fail++; $display("FAIL rst_out_last got=%0h exp=0", bus.out_last_o); end
      n_checks++; if (bus.in_ready_o !== 4'b0000) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0000", bus.in_ready_o); end
      rst = 1'b0;
      #1;
      n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rel_out_valid got=%0h exp=0", bus.out_valid_o); end
      n_checks++; if (bus.in_ready_o !== 4'b0001) begin n_fail++; $display("FAIL rel_in_ready got=%b exp=0001", bus.in_ready_o); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL rr_valid beat=%0d got=%0h exp=1", i, bus.out_valid_o); end
         n_checks++; if (bus.out_ch_o !== 2'(i % 4)) begin n_fail++; $display("FAIL rr_ch beat=%0d got=%0d exp=%0d", i, bus.out_ch_o, i % 4); end
         n_checks++; if (bus.out_data_o !== 8'(8'h10 + i % 4)) begin n_fail++; $display("FAIL rr_data beat=%0d got=%0h exp=%0h", i, bus.out_data_o, 8'h10 + i % 4); end
      end
      bus.in_valid_i = 4'b0000;
      tick();
      n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rr_drain got=%0h exp=0", bus.out_valid_o); end
   endtask

   task automatic test_fixed_select();
      mode = 1'b0; sel = 2'd2;
      bus.in_valid_i = 4'b0101; bus.in_last_i = 4'b0000;
      set_data(2, 8'hA5); set_data(0, 8'h77);
      #1;
      n_checks++; if (bus.in_ready_o !== 4'b0100) begin n_fail++; $display("FAIL fix_rdy0 got=%b exp=0100", bus.in_ready_o); end
      tick();
      n_checks++; if (bus.out_data_o !== 8'hA5) begin n_fail++; $display("FAIL fix_data0 got=%0h exp=a5", bus.out_data_o); end
      n_checks++; if (bus.out_ch_o !== 2'd2) begin n_fail++; $display("FAIL fix_ch0 got=%0d exp=2", bus.out_ch_o); end
      n_checks++; if (bus.out_last_o !== 1'b0) begin n_fail++; $display("FAIL fix_last0 got=%0h exp=0", bus.out_last_o); end
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL fix_locked0 got=%0h exp=1", locked); end
      set_data(2, 8'h5A); bus.in_last_i = 4'b0100;
      #1;
      n_checks++; if (bus.in_ready_o !== 4'b0100) begin n_fail++; $display("FAIL fix_rdy1 got=%b exp=0100", bus.in_ready_o); end
      tick();
      n_checks++; if (bus.out_data_o !== 8'h5A) begin n_fail++; $display("FAIL fix_data1 got=%0h exp=5a", bus.out_data_o); end
      n_checks++; if (bus.out_last_o !== 1'b1) begin n_fail++; $display("FAIL fix_last1 got=%0h exp=1", bus.out_last_o); end
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL fix_locked1 got=%0h exp=0", locked); end
      bus.in_valid_i = 4'b0000;
      #1;
      n_checks++; if (bus.in_ready_o !== 4'b0000) begin n_fail++; $display("FAIL fix_rdy2 got=%b exp=0000", bus.in_ready_o); end
      tick();
      n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL fix_drain got=%0h exp=0", bus.out_valid_o); end
   endtask

   task automatic test_lock();
      // Single-beat packet on ch0 leaves the pointer at 1.
      mode = 1'b0; sel = 2'd0;
      bus.in_valid_i = 4'b0001; bus.in_last_i = 4'b0001;
      tick();
      mode = 1'b1;
      bus.in_valid_i = 4'b1011; bus.in_last_i = 4'b0000;
      set_data(0, 8'h70); set_data(1, 8'hB1); set_data(3, 8'h73);
      #1;
      n_checks++; if (bus.in_ready_o !== 4'b0010) begin n_fail++; $display("FAIL lock_rdy0 got=%b exp=0010", bus.in_ready_o); end
      tick();
      n_checks++; if (bus.out_ch_o !== 2'd1) begin n_fail++; $display("FAIL lock_ch0 got=%0d exp=1", bus.out_ch_o); end
      n_checks++; if (bus.out_data_o !== 8'hB1) begin n_fail++; $display("FAIL lock_data0 got=%0h exp=b1", bus.out_data_o); end
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_locked0 got=%0h exp=1", locked); end
      // Mode/select changes mid-packet must be ignored.
      mode = 1'b0; sel = 2'd0; set_data(1, 8'hB2);
      #1;
      n_checks++; if (bus.in_ready_o !== 4'b0010) begin n_fail++; $display("FAIL lock_rdy1 got=%b exp=0010", bus.in_ready_o); end
      tick();
      n_checks++; if (bus.out_data_o !== 8'hB2) begin n_fail++; $display("FAIL lock_data1 got=%0h exp=b2", bus.out_data_o); end
      set_data(1, 8'hB3); bus.in_last_i = 4'b1010;
      #1;
      n_checks++; if (bus.in_ready_o !== 4'b0010) begin n_fail++; $display("FAIL lock_rdy2 got=%b exp=0010", bus.in_ready_o); end
      tick();
      n_checks++; if (bus.out_data_o !== 8'hB3) begin n_fail++; $display("FAIL lock_data2 got=%0h exp=b3", bus.out_data_o); end
      n_checks++; if (bus.out_last_o !== 1'b1) begin n_fail++; $display("FAIL lock_last2 got=%0h exp=1", bus.out_last_o); end
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_locked2 got=%0h exp=0", locked); end
      mode = 1'b1; bus.in_valid_i = 4'b1001;
      #1;
      n_checks++; if (bus.in_ready_o !== 4'b1000) begin n_fail++; $display("FAIL lock_next_rdy got=%b exp=1000", bus.in_ready_o); end
      tick();
      n_checks++; if (bus.out_ch_o !== 2'd3) begin n_fail++; $display("FAIL lock_next_ch got=%0d exp=3", bus.out_ch_o); end
      n_checks++; if (bus.out_data_o !== 8'h73) begin n_fail++; $display("FAIL lock_next_data got=%0h exp=73", bus.out_data_o); end
      bus.in_valid_i = 4'b0000;
      tick();
   endtask

   task automatic test_backpressure();
      mode = 1'b1;
      bus.in_valid_i = 4'b0001; bus.in_last_i = 4'b0011;
      set_data(0, 8'h33); set_data(1, 8'h44);
      tick();
      n_checks++; if (bus.out_data_o !== 8'h33) begin n_fail++; $display("FAIL bp_first got=%0h exp=33", bus.out_data_o); end
      bus.out_ready_i = 1'b0; bus.in_valid_i = 4'b0010;
      #1;
      n_checks++; if (bus.in_ready_o !== 4'b0000) begin n_fail++; $display("FAIL bp_rdy got=%b exp=0000", bus.in_ready_o); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc=%0d got=%0h exp=1", i, bus.out_valid_o); end
         n_checks++; if (bus.out_data_o !== 8'h33) begin n_fail++; $display("FAIL bp_data cyc=%0d got=%0h exp=33", i, bus.out_data_o); end
         n_checks++; if (bus.out_ch_o !== 2'd0) begin n_fail++; $display("FAIL bp_ch cyc=%0d got=%0d exp=0", i, bus.out_ch_o); end
         n_checks++; if (bus.out_last_o !== 1'b1) begin n_fail++; $display("FAIL bp_last cyc=%0d got=%0h exp=1", i, bus.out_last_o); end
         n_checks++; if (bus.in_ready_o !== 4'b0000) begin n_fail++; $display("FAIL bp_rdy cyc=%0d got=%b exp=0000", i, bus.in_ready_o); end
      end
      bus.out_ready_i = 1'b1;
      #1;
      n_checks++; if (bus.in_ready_o !== 4'b0010) begin n_fail++; $display("FAIL bp_resume_rdy got=%b exp=0010", bus.in_ready_o); end
      tick();
      n_checks++; if (bus.out_data_o !== 8'h44) begin n_fail++; $display("FAIL bp_resume_data got=%0h exp=44", bus.out_data_o); end
      n_checks++; if (bus.out_ch_o !== 2'd1) begin n_fail++; $display("FAIL bp_resume_ch got=%0d exp=1", bus.out_ch_o); end
      bus.in_valid_i = 4'b0000;
      tick();
      n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got=%0h exp=0", bus.out_valid_o); end
   endtask

   task automatic test_reset_mid_packet();
      mode = 1'b1;
      bus.in_valid_i = 4'b0100; bus.in_last_i = 4'b0000;
      set_data(2, 8'hC0);
      tick();
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL mid_locked got=%0h exp=1", locked); end
      n_checks++; if (bus.out_ch_o !== 2'd2) begin n_fail++; $display("FAIL mid_ch got=%0d exp=2", bus.out_ch_o); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%0h exp=0", bus.out_valid_o); end
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_rst_locked got=%0h exp=0", locked); end
      bus.in_valid_i = 4'b1111; bus.in_last_i = 4'b1111;
      set_data(0, 8'hD0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      n_checks++; if (bus.in_ready_o !== 4'b0001) begin n_fail++; $display("FAIL mid_restart_rdy got=%b exp=0001", bus.in_ready_o); end
      tick();
      n_checks++; if (bus.out_ch_o !== 2'd0) begin n_fail++; $display("FAIL mid_restart_ch got=%0d exp=0", bus.out_ch_o); end
      n_checks++; if (bus.out_data_o !== 8'hD0) begin n_fail++; $display("FAIL mid_restart_data got=%0h exp=d0", bus.out_data_o); end
      bus.in_valid_i = 4'b0000;
      tick();
   endtask

`ifdef STREAM_MUX_PKT_CNT_EN
   task automatic test_pkt_cnt();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_rst got=%0d exp=0", pkt_cnt); end
      mode = 1'b0; sel = 2'd0;
      bus.in_valid_i = 4'b0001; bus.in_last_i = 4'b0001;
      repeat (3) tick();
      bus.in_valid_i = 4'b0000;
      repeat (2) tick();
      n_checks++; if (pkt_cnt !== 16'd3) begin n_fail++; $display("FAIL cnt_three got=%0d exp=3", pkt_cnt); end
      bus.in_valid_i = 4'b0001;
      repeat (65532) @(posedge clk);
      #1;
      bus.in_valid_i = 4'b0000;
      repeat (2) tick();
      n_checks++; if (pkt_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_full got=%0h exp=ffff", pkt_cnt); end
      bus.in_valid_i = 4'b0001;
      tick();
      bus.in_valid_i = 4'b0000;
      repeat (2) tick();
      n_checks++; if (pkt_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_sat got=%0h exp=ffff", pkt_cnt); end
   endtask
`endif

   initial begin
      rst = 1'b1; mode = 1'b0; sel = 2'd0;
      bus.in_valid_i = '0; bus.in_last_i = '0; bus.in_data_i = '0;
      bus.out_ready_i = 1'b1;
      test_reset();
      test_fixed_select();
      test_lock();
      test_backpressure();
      test_reset_mid_packet();
`ifdef STREAM_MUX_PKT_CNT_EN
      test_pkt_cnt();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel streaming multiplexer with a registered output and valid/ready handshakes on every channel.
- Two modes, chosen at run time:
  - fixed-select: the channel is given by sel_i.
  - round-robin: arbitrates over requesting channels.
- A grant stays locked to one channel until that channel's packet ends (in_last_i).
- Sits between several producer streams and one consumer. Generalises the team's 2:1/4:1 combinational selectors to a sequential, flow-controlled block.

Parameters:
- N_CH, 4, number of input channels (2..16)
- WIDTH, 8, data bits per channel
- SEL_W, $clog2(N_CH), channel index width (derived, not overridden)

Ports:
- clk_i  input  1  single clock, rising edge
- rst_i  input  1  asynchronous, active-high reset
- mode_i  input  1  0 = fixed-select, 1 = round-robin
- sel_i  input  SEL_W  channel index used in fixed-select mode
- in_valid_i  input  N_CH  per-channel valid
- in_last_i  input  N_CH  per-channel end-of-packet flag
- in_data_i  input  N_CH*WIDTH  packed data; channel k occupies bits [k*WIDTH +: WIDTH]
- in_ready_o  output  N_CH  per-channel ready
- out_valid_o  output  1  output register holds a beat
- out_data_o  output  WIDTH  registered data
- out_last_o  output  1  registered last flag
- out_ch_o  output  SEL_W  source channel of the current output beat
- out_ready_i  input  1  consumer accepts a beat when out_valid_o && out_ready_i
- locked_o  output  1  high while mid-packet (FSM in LOCK)

Behaviour:
- Reset (async assert, released synchronously to clk_i):
  - out_valid_o=0, out_data_o=0, out_last_o=0, out_ch_o=0, locked_o=0.
  - FSM=IDLE, round-robin pointer=0, in_ready_o=0.
- Output stage: one register.
  - load_en = !out_valid_o || out_ready_i.
  - Latency is exactly 1 cycle from accepted input beat to out_valid_o.
  - Full throughput of one beat per cycle when out_ready_i stays high.
- Candidate channel g, selected combinationally each cycle:
  - IDLE, mode_i=0: g=sel_i. A request exists if in_valid_i[sel_i].
  - IDLE, mode_i=1: g = first k with in_valid_i[k], searching from ptr upward and wrapping modulo N_CH.
  - LOCK: g=lock_ch. mode_i and sel_i are ignored.
- in_ready_o[g] = load_en && (a request exists, or FSM is LOCK). All other bits are 0. At most one bit is ever high.
- A beat transfers on channel g when in_valid_i[g] && in_ready_o[g].
  - out_data_o, out_last_o and out_ch_o load from that channel. out_valid_o is set.
- If load_en holds but no transfer happens, out_valid_o clears on that edge.
- If load_en is 0, all output registers hold, including while backpressured.
- FSM transitions:
  - IDLE -> LOCK when a beat transfers with in_last_i[g]=0. lock_ch<=g.
  - IDLE stays IDLE on a single-beat packet (last=1).
  - LOCK -> IDLE when a beat transfers on lock_ch with in_last_i=1.
  - In LOCK, other channels get in_ready=0 even when valid.
- Round-robin pointer: updated when a packet completes (transfer with last=1).
  - ptr <= (g+1) mod N_CH, wrapping from N_CH-1 to 0.
  - Also updated in fixed-select mode, so a switch to round-robin starts after the last-served channel.
- sel_i >= N_CH (only possible when N_CH is not a power of 2): treated as no request. No in_ready_o bit asserts.
- mode_i or sel_i change mid-packet: no effect until FSM returns to IDLE.
- Lock is not released on an in_valid_i drop. The FSM waits in LOCK indefinitely.
- Reset mid-packet: the output beat is discarded and the FSM returns to IDLE. The upstream producer must restart the packet.

Optional Feature:
- Macro: STREAM_MUX_PKT_CNT_EN.
- When defined:
  - Adds output port pkt_cnt_o [16].
  - Counts packets completed at the output (out_valid_o && out_ready_i && out_last_o).
  - Saturates at 16'hFFFF. Reset to 0 by rst_i.
- When undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Reset with all inputs valid -> after release, out_valid_o=0 until the first edge. First edge with mode_i=1, in_valid_i=4'b1111, last=1 -> out_ch_o=0. Following beats give out_ch_o=1,2,3,0.
- mode_i=0, sel_i=2, ch2 sends data 8'hA5/8'h5A, last on the second beat, out_ready_i=1 -> out_data_o shows A5 then 5A in consecutive cycles. Only in_ready_o[2] is ever high. locked_o is high for exactly one cycle.
- mode_i=1, ch1 starts a 3-beat packet while ch0 and ch3 are valid -> in_ready_o[0] and in_ready_o[3] stay 0 until ch1's last beat. Next grant is ch3 (ptr=2, so ch2 is checked first and is not valid).
- out_ready_i=0 for 5 cycles while out_valid_o=1 -> out_data_o, out_ch_o and out_last_o are stable. in_ready_o=0. No beat is lost or duplicated when out_ready_i returns to 1.
- Assert rst_i mid-packet (locked_o=1) -> out_valid_o=0 and locked_o=0 immediately. After release, round-robin restarts at ch0.
- With STREAM_MUX_PKT_CNT_EN defined, send 3 packets -> pkt_cnt_o=3. Force the count to 16'hFFFF and send one more packet -> pkt_cnt_o stays 16'hFFFF.
